riu_decode_pipe: RTL and testbench

Registered, flow-controlled instruction decode stage for the RV32IM-subset core. It replaces the purely combinational control unit with a one-entry output register, valid/ready handshakes on both sides, multi-cycle stall sequencing for the multiply class, flush support, and a parametrised number of GPIO CSR output channels. It sits between instruction fetch and the execute/writeback datapath.

---
 rtl/riu_pkg.sv | 56 +++++
 rtl/riu_decode_pipe_decoder.sv | 118 +++++++++++
 rtl/riu_decode_pipe.sv | 121 ++++++++++++
 tb/tb_riu_decode_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riu_pkg.sv
// Shared types and constants for the RV32IM-subset decode stage.
package riu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_ADD   = 4'b0011,
    ALU_SUB   = 4'b0100,
    ALU_MUL   = 4'b0101,
    ALU_MULH  = 4'b0110,
    ALU_MULHU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_SRL   = 4'b1011,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_SW  = 2'b00,
    SEL_IMM = 2'b01,
    SEL_ALU = 2'b10
  } regsel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_SW        = 12'hF00;
  localparam logic [11:0] CSR_GPIO_BASE = 12'hF02;
  localparam int          GPIO_MAX      = 8;

  typedef struct packed {
    logic                alusrc;
    logic                regwrite;
    regsel_e             regsel;
    alu_op_e             op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         imm;
    logic [GPIO_MAX-1:0] gpio_we;
    logic                illegal;
  } ctl_bundle_t;

  // Unsupported encodings still travel down the pipe, with every control quiet.
  function automatic ctl_bundle_t illegal_bundle();
    ctl_bundle_t b;
    b         = '0;
    b.illegal = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/riu_decode_pipe_decoder.sv
// Combinational instruction decoder: raw word to control bundle plus multiply flag.
module riu_decoder
  import riu_pkg::*;
#(
  parameter int NUM_GPIO = 1
) (
  input  logic [31:0] instr,
  output ctl_bundle_t ctl,
  output logic        is_mul
);

  ctl_bundle_t ctl_s;
  logic        legal_s;
  logic        mul_s;
  logic [6:0]  opcode_s;
  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [11:0] csr_addr_s;
  logic [11:0] gpio_k_s;

  assign opcode_s   = instr[6:0];
  assign funct7_s   = instr[31:25];
  assign funct3_s   = instr[14:12];
  assign csr_addr_s = instr[31:20];
  assign gpio_k_s   = csr_addr_s - CSR_GPIO_BASE;

  // Field decode; anything not explicitly recognised clears legal_s.
  always_comb begin
    ctl_s   = '0;
    legal_s = 1'b0;
    mul_s   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        ctl_s.regwrite = 1'b1;
        ctl_s.regsel   = SEL_ALU;
        ctl_s.rd       = instr[11:7];
        ctl_s.rs1      = instr[19:15];
        ctl_s.rs2      = instr[24:20];
        legal_s        = 1'b1;
        case ({funct7_s, funct3_s})
          {7'h00, 3'b000}: ctl_s.op = ALU_ADD;
          {7'h00, 3'b001}: ctl_s.op = ALU_SLL;
          {7'h00, 3'b010}: ctl_s.op = ALU_SLT;
          {7'h00, 3'b011}: ctl_s.op = ALU_SLTU;
          {7'h00, 3'b100}: ctl_s.op = ALU_XOR;
          {7'h00, 3'b101}: ctl_s.op = ALU_SRL;
          {7'h00, 3'b110}: ctl_s.op = ALU_OR;
          {7'h00, 3'b111}: ctl_s.op = ALU_AND;
          {7'h20, 3'b000}: ctl_s.op = ALU_SUB;
          {7'h20, 3'b101}: ctl_s.op = ALU_SRA;
          {7'h01, 3'b000}: begin ctl_s.op = ALU_MUL;   mul_s = 1'b1; end
          {7'h01, 3'b001}: begin ctl_s.op = ALU_MULH;  mul_s = 1'b1; end
          {7'h01, 3'b011}: begin ctl_s.op = ALU_MULHU; mul_s = 1'b1; end
          default:         legal_s = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        ctl_s.alusrc   = 1'b1;
        ctl_s.regwrite = 1'b1;
        ctl_s.regsel   = SEL_ALU;
        ctl_s.rd       = instr[11:7];
        ctl_s.rs1      = instr[19:15];
        ctl_s.imm      = {{20{instr[31]}}, instr[31:20]};
        legal_s        = 1'b1;
        case (funct3_s)
          3'b000: ctl_s.op = ALU_ADD;
          3'b111: ctl_s.op = ALU_AND;
          3'b110: ctl_s.op = ALU_OR;
          3'b100: ctl_s.op = ALU_XOR;
          3'b001: begin
            ctl_s.op  = ALU_SLL;
            ctl_s.imm = {27'd0, instr[24:20]};
            legal_s   = (funct7_s == 7'h00);
          end
          3'b101: begin
            ctl_s.imm = {27'd0, instr[24:20]};
            if (funct7_s == 7'h00) begin
              ctl_s.op = ALU_SRL;
            end else if (funct7_s == 7'h20) begin
              ctl_s.op = ALU_SRA;
            end else begin
              legal_s = 1'b0;
            end
          end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_LUI: begin
        ctl_s.regwrite = 1'b1;
        ctl_s.regsel   = SEL_IMM;
        ctl_s.rd       = instr[11:7];
        ctl_s.imm      = {instr[31:12], 12'd0};
        legal_s        = 1'b1;
      end
      OPC_SYSTEM: begin
        ctl_s.rs1 = instr[19:15];
        if (funct3_s != 3'b001) begin
          legal_s = 1'b0;
        end else if (csr_addr_s == CSR_SW) begin
          ctl_s.regwrite = 1'b1;
          ctl_s.regsel   = SEL_SW;
          ctl_s.rd       = instr[11:7];
          legal_s        = 1'b1;
        end else if ((csr_addr_s >= CSR_GPIO_BASE) && (gpio_k_s < 12'(NUM_GPIO))) begin
          ctl_s.gpio_we = 8'd1 << gpio_k_s[2:0];
          legal_s       = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign ctl    = legal_s ? ctl_s : illegal_bundle();
  assign is_mul = legal_s && mul_s;

endmodule

// File: rtl/riu_decode_pipe.sv
// Registered decode stage: valid/ready on both sides, multiply stall sequencing, flush.
module riu_decode_pipe
  import riu_pkg::*;
#(
  parameter int NUM_GPIO = 1,
  parameter int MUL_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  input  logic                flush,
  output logic                ctl_valid,
  input  logic                ctl_ready,
  output logic                alusrc,
  output logic                regwrite,
  output logic [1:0]          regsel,
  output logic [3:0]          op,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [31:0]         imm,
  output logic [NUM_GPIO-1:0] gpio_we,
  output logic                illegal,
  output logic                busy
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic       MUL_SEQ = (MUL_LAT > 1);

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic        ctl_valid_r;
  ctl_bundle_t hold_r;
  ctl_bundle_t out_r;
  ctl_bundle_t dec_s;
  logic        is_mul_s;
  logic        in_xfer_s;
  logic        out_xfer_s;
  logic        gpio_unused_s;

  riu_decoder #(.NUM_GPIO(NUM_GPIO)) u_decoder (
    .instr  (instr),
    .ctl    (dec_s),
    .is_mul (is_mul_s)
  );

  assign instr_ready = !flush && (state_r == ST_IDLE) && (!ctl_valid_r || ctl_ready);
  assign in_xfer_s   = instr_valid && instr_ready;
  assign out_xfer_s  = ctl_valid_r && ctl_ready;

  // Stage FSM: output register, hidden multiply register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      ctl_valid_r <= 1'b0;
      hold_r      <= '0;
      out_r       <= '0;
    end else if (flush) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      ctl_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_xfer_s && is_mul_s && MUL_SEQ) begin
            // Accepting implies the output register is empty or draining now.
            hold_r      <= dec_s;
            cnt_r       <= MUL_CNT;
            state_r     <= ST_MUL_WAIT;
            ctl_valid_r <= 1'b0;
          end else if (in_xfer_s) begin
            out_r       <= dec_s;
            ctl_valid_r <= 1'b1;
          end else if (out_xfer_s) begin
            ctl_valid_r <= 1'b0;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_r == 4'd1) begin
            out_r       <= hold_r;
            ctl_valid_r <= 1'b1;
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (out_xfer_s) begin
              ctl_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign ctl_valid     = ctl_valid_r;
  assign busy          = (state_r == ST_MUL_WAIT);
  assign alusrc        = out_r.alusrc;
  assign regwrite      = out_r.regwrite;
  assign regsel        = out_r.regsel;
  assign op            = out_r.op;
  assign rd            = out_r.rd;
  assign rs1           = out_r.rs1;
  assign rs2           = out_r.rs2;
  assign imm           = out_r.imm;
  assign gpio_we       = out_r.gpio_we[NUM_GPIO-1:0];
  assign illegal       = out_r.illegal;
  assign gpio_unused_s = ^{out_r.gpio_we, hold_r.gpio_we};

endmodule

// File: tb/tb_riu_decode_pipe.sv
// Directed scenarios plus a randomized stream checked against a transaction-level model.
module tb_riu_decode_pipe;

  localparam int NUM_GPIO = 3;
  localparam int MUL_LAT  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic                flush;
  logic                ctl_valid;
  logic                ctl_ready;
  logic                alusrc;
  logic                regwrite;
  logic [1:0]          regsel;
  logic [3:0]          op;
  logic [4:0]          rd, rs1, rs2;
  logic [31:0]         imm;
  logic [NUM_GPIO-1:0] gpio_we;
  logic                illegal;
  logic                busy;
  logic [58:0]         obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [58:0] b;
    int          t;
  } exp_t;
  exp_t q[$];

  riu_decode_pipe #(.NUM_GPIO(NUM_GPIO), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .flush(flush), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .alusrc(alusrc), .regwrite(regwrite), .regsel(regsel), .op(op), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .gpio_we(gpio_we), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {alusrc, regwrite, regsel, op, rd, rs1, rs2, imm, gpio_we, illegal};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode from the instruction-set rules; packed like obs.
  function automatic logic [58:0] ref_bundle(input logic [31:0] w);
    logic a, rw, ok;
    logic [1:0] sel;
    logic [3:0] o;
    logic [4:0] d, s1, s2;
    logic [31:0] im;
    logic [2:0] g;
    logic [6:0] f7;
    logic [2:0] f3;
    int addr;
    {a, rw, ok, sel, o, d, s1, s2, im, g} = '0;
    f7 = w[31:25];
    f3 = w[14:12];
    addr = int'(w[31:20]);
    case (w[6:0])
      7'b0110011: begin
        ok = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: o = 4'd3;  3'd1: o = 4'd8;  3'd2: o = 4'd12; 3'd3: o = 4'd13;
            3'd4: o = 4'd2;  3'd5: o = 4'd11; 3'd6: o = 4'd1;  default: o = 4'd0;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) o = 4'd4;
        else if (f7 == 7'h20 && f3 == 3'd5) o = 4'd9;
        else if (f7 == 7'h01 && f3 == 3'd0) o = 4'd5;
        else if (f7 == 7'h01 && f3 == 3'd1) o = 4'd6;
        else if (f7 == 7'h01 && f3 == 3'd3) o = 4'd7;
        else ok = 1'b0;
        rw = 1'b1; sel = 2'b10; d = w[11:7]; s1 = w[19:15]; s2 = w[24:20];
      end
      7'b0010011: begin
        ok = 1'b1;
        im = {{20{w[31]}}, w[31:20]};
        case (f3)
          3'd0: o = 4'd3;
          3'd7: o = 4'd0;
          3'd6: o = 4'd1;
          3'd4: o = 4'd2;
          3'd1: begin o = 4'd8; im = 32'(w[24:20]); ok = (f7 == 7'h00); end
          3'd5: begin
            im = 32'(w[24:20]);
            o = (f7 == 7'h20) ? 4'd9 : 4'd11;
            ok = (f7 == 7'h00) || (f7 == 7'h20);
          end
          default: ok = 1'b0;
        endcase
        a = 1'b1; rw = 1'b1; sel = 2'b10; d = w[11:7]; s1 = w[19:15];
      end
      7'b0110111: begin
        ok = 1'b1; rw = 1'b1; sel = 2'b01; d = w[11:7]; im = {w[31:12], 12'd0};
      end
      7'b1110011: begin
        s1 = w[19:15];
        if (f3 == 3'd1 && addr == 'hF00) begin
          ok = 1'b1; rw = 1'b1; d = w[11:7];
        end else if (f3 == 3'd1 && addr >= 'hF02 && addr < 'hF02 + NUM_GPIO) begin
          ok = 1'b1; g = 3'(1 << (addr - 'hF02));
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {58'd0, 1'b1};
    return {a, rw, sel, o, d, s1, s2, im, g, 1'b0};
  endfunction

  function automatic bit ref_is_mul(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) && (w[31:25] == 7'h01) &&
           (w[14:12] == 3'd0 || w[14:12] == 3'd1 || w[14:12] == 3'd3);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] f7;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: begin w[6:0] = 7'b0110011; w[31:25] = f7; end
      1: begin w[6:0] = 7'b0010011; w[31:25] = f7; end
      2: w[6:0] = 7'b0110111;
      3: begin
        w[6:0] = 7'b1110011;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b001;
        if ($urandom_range(0, 3) != 0) w[31:20] = 12'hF00 + 12'($urandom_range(0, 6));
      end
      4: begin
        w[6:0] = 7'b0110011; w[31:25] = 7'h01;
        case ($urandom_range(0, 2))
          0: w[14:12] = 3'd0;
          1: w[14:12] = 3'd1;
          default: w[14:12] = 3'd3;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] I_ADDI  = {12'hFFB, 5'd0, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] I_LUI   = {20'h12345, 5'd2, 7'b0110111};
  localparam logic [31:0] I_MUL   = {7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_SUB   = {7'h20, 5'd7, 5'd6, 3'b000, 5'd5, 7'b0110011};
  localparam logic [31:0] I_GPIO2 = {12'hF04, 5'd4, 3'b001, 5'd0, 7'b1110011};
  localparam logic [31:0] I_CSRX  = {12'hF05, 5'd4, 3'b001, 5'd0, 7'b1110011};
  localparam logic [31:0] I_SRLIX = {7'b0100001, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011};

  initial begin
    int cyc;
    logic exp_v, exp_b, exp_r;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; flush = 1'b0; ctl_ready = 1'b1;
    #12;
    check_eq("rst_valid", ctl_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bundle", obs, 0);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back addi then lui
    @(negedge clk); instr_valid = 1'b1; instr = I_ADDI;
    #1 check_eq("b2b_ready", instr_ready, 1);
    @(negedge clk); instr = I_LUI;
    check_eq("addi_valid", ctl_valid, 1);
    check_eq("addi_op", op, 4'b0011);
    check_eq("addi_alusrc", alusrc, 1);
    check_eq("addi_imm", imm, 32'hFFFFFFFB);
    check_eq("addi_bundle", obs, ref_bundle(I_ADDI));
    @(negedge clk); instr_valid = 1'b0;
    check_eq("lui_valid", ctl_valid, 1);
    check_eq("lui_regsel", regsel, 2'b01);
    check_eq("lui_imm", imm, 32'h12345000);

    // multiply latency
    @(negedge clk); instr_valid = 1'b1; instr = I_MUL;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); instr_valid = 1'b0;
      #1;
      check_eq($sformatf("mul_busy%0d", k), busy, 1);
      check_eq($sformatf("mul_ready%0d", k), instr_ready, 0);
      check_eq($sformatf("mul_valid%0d", k), ctl_valid, 0);
    end
    @(negedge clk);
    check_eq("mul_done_valid", ctl_valid, 1);
    check_eq("mul_op", op, 4'b0101);
    check_eq("mul_done_busy", busy, 0);

    // backpressure on sub
    @(negedge clk); ctl_ready = 1'b0; instr_valid = 1'b1; instr = I_SUB;
    #1 check_eq("bp_accept", instr_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); instr = I_ADDI;
      #1;
      check_eq("bp_valid", ctl_valid, 1);
      check_eq("bp_bundle", obs, ref_bundle(I_SUB));
      check_eq("bp_ready", instr_ready, 0);
    end
    @(negedge clk); ctl_ready = 1'b1; instr_valid = 1'b0;
    #1 check_eq("bp_drain_ready", instr_ready, 1);
    @(negedge clk);
    check_eq("bp_drained", ctl_valid, 0);

    // GPIO CSR and illegal encodings
    instr_valid = 1'b1; instr = I_GPIO2;
    @(negedge clk); instr = I_CSRX;
    check_eq("gpio_we", gpio_we, 3'b100);
    check_eq("gpio_regwrite", regwrite, 0);
    @(negedge clk); instr = I_SRLIX;
    check_eq("csrx_illegal", illegal, 1);
    check_eq("csrx_gpio", gpio_we, 3'b000);
    @(negedge clk); instr_valid = 1'b0;
    check_eq("srli_illegal", obs, {58'd0, 1'b1});

    // flush during MUL_WAIT
    @(negedge clk); instr_valid = 1'b1; instr = I_MUL;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); flush = 1'b1; instr_valid = 1'b1; instr = I_ADDI;
    #1 check_eq("flush_ready", instr_ready, 0);
    @(negedge clk); flush = 1'b0; instr_valid = 1'b0;
    #1;
    check_eq("flush_busy", busy, 0);
    check_eq("flush_valid", ctl_valid, 0);
    repeat (4) @(negedge clk);
    check_eq("flush_dropped", ctl_valid, 0);

    // asynchronous reset with a held bundle
    ctl_ready = 1'b0; instr_valid = 1'b1; instr = I_ADDI;
    @(negedge clk); instr_valid = 1'b0;
    check_eq("hold_valid", ctl_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", ctl_valid, 0);
    check_eq("arst_bundle", obs, 0);
    @(negedge clk); rst_n = 1'b1; ctl_ready = 1'b1;

    // reset mid-multiply drops it
    @(negedge clk); instr_valid = 1'b1; instr = I_MUL;
    @(negedge clk); instr_valid = 1'b0;
    check_eq("rmul_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_eq("rmul_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rmul_dropped", ctl_valid, 0);

    // randomized stream against the transaction model
    cyc = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = gen_instr();
      ctl_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      if (flush) ctl_ready = 1'b0;
      #1;
      exp_v = (q.size() > 0) && (cyc >= q[0].t);
      exp_b = (q.size() > 0) && (cyc < q[0].t);
      exp_r = !flush && !exp_b && (!exp_v || ctl_ready);
      check_eq("rnd_valid", ctl_valid, exp_v);
      check_eq("rnd_busy", busy, exp_b);
      check_eq("rnd_ready", instr_ready, exp_r);
      if (exp_v) check_eq("rnd_bundle", obs, q[0].b);
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (exp_v && ctl_ready) void'(q.pop_front());
        if (instr_valid && exp_r)
          q.push_back('{b: ref_bundle(instr), t: cyc + (ref_is_mul(instr) ? MUL_LAT : 1)});
      end
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
